// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide engine owning the HI/LO register pair.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0] mb_q, mb_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
    logic [CW-1:0] cnt_q, cnt_d;
    logic div_q, div_d, sign_q, sign_d, rsign_q, rsign_d, dz_q, dz_d;
    logic done_q, done_d, div_zero_q, div_zero_d, a_neg, b_neg, ge;
    logic [WIDTH:0] add, sub;
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        add = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mb_q & {WIDTH{acc_q[0]}}};
        sub = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mb_q};
        ge = ~sub[WIDTH];
        prod = sign_q ? -acc_q : acc_q;
        quo = sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        state_d = state_q;
        acc_d = acc_q;
        mb_d = mb_q;
        a_d = a_q;
        cnt_d = cnt_q;
        div_d = div_q;
        sign_d = sign_q;
        rsign_d = rsign_q;
        dz_d = dz_q;
        hi_d = hi_q;
        lo_d = lo_q;
        done_d = 1'b0;
        div_zero_d = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE && start && !op[2]) begin
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            state_d = CALC;
            acc_d = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            mb_d = op[1] ? b_mag : a_mag;
            a_d = a;
            cnt_d = CW'(WIDTH - 1);
            div_d = op[1];
            sign_d = a_neg ^ b_neg;
            rsign_d = a_neg;
            dz_d = op[1] & (b == '0);
        end else if (state_q == IDLE && start && op[2:1] == 2'b10) begin
            hi_d = op[0] ? hi_q : a;
            lo_d = op[0] ? a : lo_q;
            done_d = 1'b1;
        end else if (state_q == CALC) begin
            acc_d = div_q ? {ge ? sub[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], ge}
                          : {add, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            state_d = (cnt_q == '0) ? FIX : CALC;
        end else if (state_q == FIX) begin
            state_d = IDLE;
            done_d = 1'b1;
            div_zero_d = dz_q;
            hi_d = div_q ? (dz_q ? a_q : rem) : prod[2*WIDTH-1:WIDTH];
            lo_d = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            mb_q <= '0;
            a_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
            sign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            done_q <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            mb_q <= mb_d;
            a_q <= a_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
            sign_q <= sign_d;
            rsign_q <= rsign_d;
            dz_q <= dz_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            done_q <= done_d;
            div_zero_q <= div_zero_d;
        end
    end
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign div_zero = div_zero_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0] op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, div_zero;
    logic [W-1:0] hi, lo;
    int checks = 0, errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic dz);
        longint sx, sy, q, r;
        logic [63:0] u;
        dz = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 3'd0) begin
            u = 64'(sx * sy);
            m_hi = u[63:32];
            m_lo = u[31:0];
        end else if (o == 3'd1) begin
            u = {32'd0, x} * {32'd0, y};
            m_hi = u[63:32];
            m_lo = u[31:0];
        end else if (o == 3'd2 || o == 3'd3) begin
            if (y == 32'd0) begin
                dz = 1'b1;
                m_lo = '1;
                m_hi = x;
            end else begin
                if (o == 3'd3) begin
                    sx = longint'({32'd0, x});
                    sy = longint'({32'd0, y});
                end
                q = sx / sy;
                r = sx % sy;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
        end else if (o == 3'd4) begin
            m_hi = x;
        end else if (o == 3'd5) begin
            m_lo = x;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic dz;
        int n;
        logic [31:0] ohi, olo;
        ohi = m_hi;
        olo = m_lo;
        model(o, x, y, dz);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 3'($urandom_range(7));
        if (!o[2]) begin
            n = 0;
            while (busy && n < 200) begin
                if (n == W / 2) begin
                    chk({tag, "_hold_hi"}, hi, ohi);
                    chk({tag, "_hold_lo"}, lo, olo);
                end
                n++;
                @(negedge clk);
            end
            chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        end else begin
            chk({tag, "_busy"}, 32'(busy), 32'd0);
        end
        chk({tag, "_done"}, 32'(done), 32'(o[2:1] != 2'b11));
        chk({tag, "_dz"}, 32'(div_zero), 32'(dz));
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [2:0] o;
        logic [31:0] x, y;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd7);
        chk("mult_hi_k", hi, 32'hFFFFFFFF);
        chk("mult_lo_k", lo, 32'hFFFFFFEB);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_hi_k", hi, 32'hFFFFFFFE);
        chk("multu_lo_k", lo, 32'h00000001);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
        chk("div_neg_lo_k", lo, 32'hFFFFFFFD);
        chk("div_neg_hi_k", hi, 32'hFFFFFFFF);
        run_op("divu", 3'd3, 32'd7, 32'd2);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo_k", lo, 32'h80000000);
        chk("div_ovf_hi_k", hi, 32'd0);
        run_op("div_zero", 3'd2, 32'h12345678, 32'd0);
        chk("div_zero_lo_k", lo, 32'hFFFFFFFF);
        chk("div_zero_hi_k", hi, 32'h12345678);
        run_op("divu_zero", 3'd3, 32'h80000001, 32'd0);

        run_op("mtlo", 3'd5, 32'hAAAA0000, 32'd0);
        op = 3'd0;
        a = 32'd5;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd4;
        a = 32'h00005555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_lo", lo, 32'hAAAA0000);
        chk("flush_hi", hi, m_hi);
        @(negedge clk);
        chk("flush_no_done", 32'(done), 32'd0);
        flush = 1'b1;
        start = 1'b1;
        op = 3'd5;
        a = 32'h00001234;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk("flush_start_lo", lo, 32'hAAAA0000);
        chk("flush_start_done", 32'(done), 32'd0);
        chk("flush_start_busy", 32'(busy), 32'd0);

        op = 3'd3;
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_dz", 32'(div_zero), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        run_op("divu_after_rst", 3'd3, 32'd100, 32'd7);
        chk("divu_after_rst_lo_k", lo, 32'd14);
        chk("divu_after_rst_hi_k", hi, 32'd2);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(7));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(5) == 0) y = 32'd0;
            if ($urandom_range(7) == 0) y = 32'($urandom_range(15));
            if ($urandom_range(9) == 0) begin
                x = 32'h80000000;
                y = 32'hFFFFFFFF;
            end
            run_op($sformatf("rnd%0d_op%0d", i, o), o, x, y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
